// File: rtl/control_pkg.sv
// Shared types for the accumulator-machine control unit:
// opcodes, ALU ops, accumulator-input selects, sequencer states.
package control_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 5;
  localparam int OPND_W  = INSTR_W - OPC_W;

  typedef enum logic [4:0] {
    OP_HLT  = 5'd0,
    OP_STO  = 5'd1,
    OP_LD   = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7,
    OP_BEQ  = 5'd8,
    OP_BNE  = 5'd9,
    OP_BGT  = 5'd10,
    OP_BGE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BLE  = 5'd13,
    OP_JMP  = 5'd14,
    OP_NOT  = 5'd15,
    OP_AND  = 5'd16,
    OP_ANDI = 5'd17,
    OP_OR   = 5'd18,
    OP_ORI  = 5'd19,
    OP_XOR  = 5'd20,
    OP_XORI = 5'd21,
    OP_SLL  = 5'd22,
    OP_SRL  = 5'd23
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  localparam logic [1:0] SEL_A_IMM = 2'b00;
  localparam logic [1:0] SEL_A_MEM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_GT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LT   = 3'd5,
    BR_LE   = 3'd6,
    BR_ALW  = 3'd7
  } br_cond_e;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    alu_op_e    alu_op;
    logic       wr_acc;
    logic       wr_mem;
    logic       is_alu;
    br_cond_e   br;
  } dec_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction and ALU status in,
// strobes, selects and operand out.
interface control_unit_if #(
  parameter int INSTR_WIDTH  = 16,
  parameter int OPCODE_WIDTH = 5
);
  localparam int OPND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

  logic [INSTR_WIDTH-1:0] instr_in;
  logic                   alu_zero;
  logic                   alu_neg;
  logic [OPND_WIDTH-1:0]  operand;
  logic                   ir_wr;
  logic                   pc_wr;
  logic                   pc_sel;
  logic [1:0]             sel_A;
  logic                   sel_B;
  logic [2:0]             alu_op;
  logic                   acc_wr;
  logic                   mem_wr;
  logic                   halted;

  modport master (
    input  instr_in, alu_zero, alu_neg,
    output operand, ir_wr, pc_wr, pc_sel,
    output sel_A, sel_B, alu_op,
    output acc_wr, mem_wr, halted
  );

  modport slave (
    output instr_in, alu_zero, alu_neg,
    input  operand, ir_wr, pc_wr, pc_sel,
    input  sel_A, sel_B, alu_op,
    input  acc_wr, mem_wr, halted
  );

endinterface

// File: rtl/control_unit_instr_decoder.sv
// Combinational opcode decode into datapath selects, write
// intents and branch condition.
module instr_decoder
  import control_pkg::*;
(
  input  opcode_e op_i,
  output dec_t    dec_o
);

  function automatic dec_t alu_dec(
    input alu_op_e op,
    input logic    imm
  );
    dec_t d;
    d        = '0;
    d.sel_a  = SEL_A_ALU;
    d.sel_b  = imm;
    d.alu_op = op;
    d.wr_acc = 1'b1;
    d.is_alu = 1'b1;
    return d;
  endfunction

  always_comb begin
    dec_o = '0;
    case (op_i)
      OP_STO:  dec_o.wr_mem = 1'b1;
      OP_LD: begin
        dec_o.sel_a  = SEL_A_MEM;
        dec_o.wr_acc = 1'b1;
      end
      OP_LDI: begin
        dec_o.sel_a  = SEL_A_IMM;
        dec_o.wr_acc = 1'b1;
      end
      OP_ADD:  dec_o = alu_dec(ALU_ADD, 1'b0);
      OP_ADDI: dec_o = alu_dec(ALU_ADD, 1'b1);
      OP_SUB:  dec_o = alu_dec(ALU_SUB, 1'b0);
      OP_SUBI: dec_o = alu_dec(ALU_SUB, 1'b1);
      OP_NOT:  dec_o = alu_dec(ALU_NOT, 1'b0);
      OP_AND:  dec_o = alu_dec(ALU_AND, 1'b0);
      OP_ANDI: dec_o = alu_dec(ALU_AND, 1'b1);
      OP_OR:   dec_o = alu_dec(ALU_OR, 1'b0);
      OP_ORI:  dec_o = alu_dec(ALU_OR, 1'b1);
      OP_XOR:  dec_o = alu_dec(ALU_XOR, 1'b0);
      OP_XORI: dec_o = alu_dec(ALU_XOR, 1'b1);
      OP_SLL:  dec_o = alu_dec(ALU_SLL, 1'b1);
      OP_SRL:  dec_o = alu_dec(ALU_SRL, 1'b1);
      OP_BEQ:  dec_o.br = BR_EQ;
      OP_BNE:  dec_o.br = BR_NE;
      OP_BGT:  dec_o.br = BR_GT;
      OP_BGE:  dec_o.br = BR_GE;
      OP_BLT:  dec_o.br = BR_LT;
      OP_BLE:  dec_o.br = BR_LE;
      OP_JMP:  dec_o.br = BR_ALW;
      default: dec_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: IR, Z/N flags and strobe gating for the
// accumulator datapath; three cycles per instruction.
module control_unit
  import control_pkg::*;
#(
  parameter int INSTR_WIDTH  = 16,
  parameter int OPCODE_WIDTH = 5
) (
  input logic            clk,
  input logic            rst_n,
  control_unit_if.master bus
);

  localparam int OPND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   z_q, z_d;
  logic                   n_q, n_d;
  opcode_e                op;
  dec_t                   dec;
  logic                   take;

  assign op = opcode_e'(
    ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH]);

  instr_decoder u_dec (
    .op_i  (op),
    .dec_o (dec)
  );

  always_comb begin
    take = 1'b0;
    unique case (dec.br)
      BR_NONE: take = 1'b0;
      BR_EQ:   take = z_q;
      BR_NE:   take = !z_q;
      BR_GT:   take = !z_q && !n_q;
      BR_GE:   take = !n_q;
      BR_LT:   take = n_q;
      BR_LE:   take = n_q || z_q;
      BR_ALW:  take = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    z_d     = z_q;
    n_d     = n_q;
    unique case (state_q)
      FETCH: begin
        state_d = DECODE;
        ir_d    = bus.instr_in;
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: begin
        state_d = (op == OP_HLT) ? HALT : FETCH;
        if (dec.is_alu) begin
          z_d = bus.alu_zero;
          n_d = bus.alu_neg;
        end
      end
      HALT:    state_d = HALT;
    endcase
  end

  // Everything is forced low while rst_n is asserted, even mid-EXECUTE.
  always_comb begin
    bus.operand = ir_q[OPND_WIDTH-1:0];
    bus.ir_wr   = 1'b0;
    bus.pc_wr   = 1'b0;
    bus.pc_sel  = 1'b0;
    bus.sel_A   = SEL_A_IMM;
    bus.sel_B   = 1'b0;
    bus.alu_op  = 3'd0;
    bus.acc_wr  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.halted  = 1'b0;
    unique case (state_q)
      FETCH:  bus.ir_wr = 1'b1;
      DECODE: begin
        bus.sel_A  = dec.sel_a;
        bus.sel_B  = dec.sel_b;
        bus.alu_op = dec.alu_op;
      end
      EXECUTE: begin
        bus.sel_A  = dec.sel_a;
        bus.sel_B  = dec.sel_b;
        bus.alu_op = dec.alu_op;
        bus.acc_wr = dec.wr_acc;
        bus.mem_wr = dec.wr_mem;
        bus.pc_wr  = (op != OP_HLT);
        bus.pc_sel = take;
      end
      HALT:   bus.halted = 1'b1;
    endcase
    if (!rst_n) begin
      bus.operand = '0;
      bus.ir_wr   = 1'b0;
      bus.pc_wr   = 1'b0;
      bus.pc_sel  = 1'b0;
      bus.sel_A   = SEL_A_IMM;
      bus.sel_B   = 1'b0;
      bus.alu_op  = 3'd0;
      bus.acc_wr  = 1'b0;
      bus.mem_wr  = 1'b0;
      bus.halted  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios plus random programs,
// checked against an instruction-level model of the strobes.
module tb_control_unit;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  control_unit_if #(.INSTR_WIDTH(16), .OPCODE_WIDTH(5)) bus ();

  control_unit #(.INSTR_WIDTH(16), .OPCODE_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: last loaded instruction and the Z/N flags
  logic [15:0] m_ir;
  logic        m_z;
  logic        m_n;

  function automatic logic is_alu_op(input int op);
    return (op >= 4 && op <= 7) || (op >= 15 && op <= 23);
  endfunction

  // ph: 0 fetch, 1 decode, 2 execute, 3 halt
  function automatic logic [22:0] exp_out(
    input int          ph,
    input logic [15:0] ir,
    input logic [10:0] opnd,
    input logic        z,
    input logic        n
  );
    int         op;
    logic       alu, imm, tk;
    logic [1:0] sa;
    logic       sb;
    int         ao;
    logic       iw, pw, ps, acc, mem, h;
    op  = int'(ir[15:11]);
    alu = is_alu_op(op);
    imm = (op == 5) || (op == 7) || (op == 17) || (op == 19)
       || (op == 21) || (op == 22) || (op == 23);
    if (op >= 4 && op <= 7) ao = (op - 4) / 2;
    else if (op >= 16 && op <= 21) ao = (op - 16) / 2 + 2;
    else if (op == 15) ao = 5;
    else if (op == 22) ao = 6;
    else if (op == 23) ao = 7;
    else ao = 0;
    sa = alu ? 2'b10 : (op == 2) ? 2'b01 : 2'b00;
    sb = alu && imm;
    case (op)
      8:  tk = z;
      9:  tk = !z;
      10: tk = !z && !n;
      11: tk = !n;
      12: tk = n;
      13: tk = n || z;
      14: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    iw = 0; pw = 0; ps = 0; acc = 0; mem = 0; h = 0;
    if (ph == 0) begin
      iw = 1; sa = 0; sb = 0; ao = 0;
    end else if (ph == 2) begin
      acc = alu || op == 2 || op == 3;
      mem = (op == 1);
      pw  = (op != 0);
      ps  = tk;
    end else if (ph == 3) begin
      h = 1; sa = 0; sb = 0; ao = 0;
    end
    return {opnd, iw, pw, ps, sa, sb, 3'(ao), acc, mem, h};
  endfunction

  task automatic model_reset();
    m_ir = 16'h0;
    m_z  = 1'b0;
    m_n  = 1'b0;
  endtask

  task automatic model_instr(
    input  logic [15:0]      ins,
    input  logic             z,
    input  logic             n,
    output logic [2:0][22:0] ex
  );
    ex[0] = exp_out(0, ins, m_ir[10:0], m_z, m_n);
    ex[1] = exp_out(1, ins, ins[10:0], m_z, m_n);
    ex[2] = exp_out(2, ins, ins[10:0], m_z, m_n);
    if (is_alu_op(int'(ins[15:11]))) begin
      m_z = z;
      m_n = n;
    end
    m_ir = ins;
  endtask

  function automatic logic [22:0] sample();
    return {bus.operand, bus.ir_wr, bus.pc_wr, bus.pc_sel,
            bus.sel_A, bus.sel_B, bus.alu_op,
            bus.acc_wr, bus.mem_wr, bus.halted};
  endfunction

  // entered at a negedge in FETCH, returns at the next FETCH negedge
  task automatic run_instr(
    input  logic [15:0]      ins,
    input  logic             z,
    input  logic             n,
    output logic [2:0][22:0] obs
  );
    #1 obs[0] = sample();
    bus.instr_in = ins;
    bus.alu_zero = 1'($urandom);
    bus.alu_neg  = 1'($urandom);
    @(negedge clk);
    bus.instr_in = 16'($urandom);
    bus.alu_zero = 1'($urandom);
    bus.alu_neg  = 1'($urandom);
    #1 obs[1] = sample();
    @(negedge clk);
    bus.alu_zero = z;
    bus.alu_neg  = n;
    #1 obs[2] = sample();
    @(negedge clk);
  endtask

  function automatic logic [15:0] mk(input int op, input int opnd);
    return {5'(op), 11'(opnd)};
  endfunction

  task automatic test_reset();
    logic [2:0][22:0] ex, obs;
    rst_n = 1'b0;
    bus.instr_in = 16'hFFFF;
    bus.alu_zero = 1'b1;
    bus.alu_neg  = 1'b1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      vecs++;
      if (sample() !== 23'h0) begin
        errs++;
        $display("FAIL reset_hold cyc%0d got %h exp 0", c, sample());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_instr(16'h1805, 1'b0, 1'b0, ex);
    run_instr(16'h1805, 1'b0, 1'b0, obs);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (obs[k] !== ex[k]) begin
        errs++;
        $display("FAIL reset_ldi ph%0d got %h exp %h", k, obs[k], ex[k]);
      end
    end
  endtask

  task automatic test_loads();
    logic [15:0] prog [2];
    logic [2:0][22:0] ex, obs;
    prog[0] = mk(2, 3);
    prog[1] = mk(5, 2);
    for (int i = 0; i < 2; i++) begin
      model_instr(prog[i], 1'b0, 1'b1, ex);
      run_instr(prog[i], 1'b0, 1'b1, obs);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (obs[k] !== ex[k]) begin
          errs++;
          $display("FAIL load_alu i%0d ph%0d got %h exp %h",
                   i, k, obs[k], ex[k]);
        end
      end
    end
  endtask

  task automatic test_branch_zero();
    logic [2:0][22:0] ex, obs;
    for (int r = 0; r < 2; r++) begin
      logic z;
      z = (r == 0);
      model_instr(mk(7, 1), z, 1'b0, ex);
      run_instr(mk(7, 1), z, 1'b0, obs);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (obs[k] !== ex[k]) begin
          errs++;
          $display("FAIL subi r%0d ph%0d got %h exp %h",
                   r, k, obs[k], ex[k]);
        end
      end
      model_instr(mk(8, 40), 1'b0, 1'b0, ex);
      run_instr(mk(8, 40), 1'b0, 1'b0, obs);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (obs[k] !== ex[k]) begin
          errs++;
          $display("FAIL beq r%0d ph%0d got %h exp %h",
                   r, k, obs[k], ex[k]);
        end
      end
    end
  endtask

  task automatic test_branch_neg();
    logic [15:0] prog [4];
    logic [2:0][22:0] ex, obs;
    prog[0] = mk(6, 4);
    prog[1] = mk(11, 7);
    prog[2] = mk(14, 12);
    prog[3] = mk(12, 7);
    for (int i = 0; i < 4; i++) begin
      model_instr(prog[i], 1'b0, (i == 0), ex);
      run_instr(prog[i], (i != 0), (i == 0), obs);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (obs[k] !== ex[k]) begin
          errs++;
          $display("FAIL neg_br i%0d ph%0d got %h exp %h",
                   i, k, obs[k], ex[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic z, n;
    logic [2:0][22:0] ex, obs;
    for (int i = 0; i < 40; i++) begin
      ins = {5'($urandom_range(31, 1)), 11'($urandom)};
      z = 1'($urandom);
      n = 1'($urandom);
      model_instr(ins, z, n, ex);
      run_instr(ins, z, n, obs);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (obs[k] !== ex[k]) begin
          errs++;
          $display("FAIL random i%0d ins %h ph%0d got %h exp %h",
                   i, ins, k, obs[k], ex[k]);
        end
      end
    end
  endtask

  task automatic test_store_halt();
    logic [2:0][22:0] ex, obs;
    logic [22:0] hx;
    model_instr(mk(1, 9), 1'b0, 1'b0, ex);
    run_instr(mk(1, 9), 1'b0, 1'b0, obs);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (obs[k] !== ex[k]) begin
        errs++;
        $display("FAIL sto ph%0d got %h exp %h", k, obs[k], ex[k]);
      end
    end
    model_instr(mk(0, 21), 1'b1, 1'b1, ex);
    run_instr(mk(0, 21), 1'b1, 1'b1, obs);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (obs[k] !== ex[k]) begin
        errs++;
        $display("FAIL hlt ph%0d got %h exp %h", k, obs[k], ex[k]);
      end
    end
    hx = exp_out(3, m_ir, m_ir[10:0], m_z, m_n);
    for (int c = 0; c < 5; c++) begin
      bus.instr_in = 16'($urandom);
      #1;
      vecs++;
      if (sample() !== hx) begin
        errs++;
        $display("FAIL halt cyc%0d got %h exp %h", c, sample(), hx);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (sample() !== 23'h0) begin
      errs++;
      $display("FAIL halt_rst got %h exp 0", sample());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset_execute();
    logic [2:0][22:0] ex, obs;
    model_instr(mk(7, 3), 1'b1, 1'b1, ex);
    run_instr(mk(7, 3), 1'b1, 1'b1, obs);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (obs[k] !== ex[k]) begin
        errs++;
        $display("FAIL pre_subi ph%0d got %h exp %h", k, obs[k], ex[k]);
      end
    end
    bus.instr_in = mk(4, 5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.alu_zero = 1'b1;
    bus.alu_neg  = 1'b1;
    #1;
    vecs++;
    if (sample() !== 23'h0) begin
      errs++;
      $display("FAIL exec_rst got %h exp 0", sample());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_instr(mk(8, 40), 1'b0, 1'b0, ex);
    run_instr(mk(8, 40), 1'b0, 1'b0, obs);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (obs[k] !== ex[k]) begin
        errs++;
        $display("FAIL post_beq ph%0d got %h exp %h", k, obs[k], ex[k]);
      end
    end
    model_instr(mk(12, 7), 1'b0, 1'b0, ex);
    run_instr(mk(12, 7), 1'b0, 1'b0, obs);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (obs[k] !== ex[k]) begin
        errs++;
        $display("FAIL post_blt ph%0d got %h exp %h", k, obs[k], ex[k]);
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_loads();
    test_branch_zero();
    test_branch_neg();
    test_random();
    test_store_halt();
    test_reset_execute();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control unit for the accumulator datapath. Holds the instruction register, a three-state instruction sequencer and the branch flags, and drives the datapath strobes: PC, IR, accumulator, data memory and ALU. It also drives the select lines of the accumulator-input mux. Instructions are 16 bits: opcode `[15:11]`, operand `[10:0]`.

## Interface
- `INSTR_WIDTH`, 16, instruction word width.
- `OPCODE_WIDTH`, 5, opcode field width (top bits of instruction).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr_in`  in  INSTR_WIDTH  instruction memory read data, valid in FETCH.
- `alu_zero`  in  1  ALU result == 0.
- `alu_neg`  in  1  ALU result MSB.
- `operand`  out  11  IR`[10:0]`, to extender and data-memory address.
- `ir_wr`  out  1  IR load strobe.
- `pc_wr`  out  1  PC update strobe.
- `pc_sel`  out  1  0 = PC+1, 1 = operand (branch target).
- `sel_A`  out  2  accumulator-input select: 00 immediate, 01 data memory, 10 ALU.
- `sel_B`  out  1  ALU operand B: 0 data memory, 1 immediate.
- `alu_op`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SLL, 111 SRL.
- `acc_wr`  out  1  accumulator write strobe.
- `mem_wr`  out  1  data memory write strobe (stores ACC).
- `halted`  out  1  high in HALT.

## Operation
- Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI, 01000 BEQ, 01001 BNE, 01010 BGT, 01011 BGE, 01100 BLT, 01101 BLE, 01110 JMP, 01111 NOT, 10000 AND, 10001 ANDI, 10010 OR, 10011 ORI, 10100 XOR, 10101 XORI, 10110 SLL, 10111 SRL. Others decode as NOP.
- States: FETCH -> DECODE -> EXECUTE -> FETCH. EXECUTE of HLT goes -> HALT. HALT is left only by reset.
- FETCH: `ir_wr`=1, IR captures `instr_in` at cycle end; all other strobes 0, selects 0.
- DECODE: `sel_A`, `sel_B` and `alu_op` are driven from IR (memory read address settles); all strobes 0.
- EXECUTE: selects held. Write enables per instruction:
  - LD: `sel_A`=01, `acc_wr`.
  - LDI: `sel_A`=00, `acc_wr`.
  - ALU ops: `sel_A`=10, `acc_wr`. `sel_B`=1 for ADDI, SUBI, ANDI, ORI, XORI, SLL, SRL; 0 otherwise.
  - STO: `mem_wr`.
  - All except HLT: `pc_wr`=1.
- ALU ops (ADD..SRL, including NOT) load flags Z and N from `alu_zero` and `alu_neg` at the EXECUTE edge. All other instructions leave the flags unchanged.
- Branch `pc_sel`=1 conditions, evaluated on the stored flags:
  - BEQ: Z.
  - BNE: !Z.
  - BGT: !Z && !N.
  - BGE: !N.
  - BLT: N.
  - BLE: N || Z.
  - JMP: always.
- HALT: all strobes and selects 0, `halted`=1.

## Timing
- Every instruction takes 3 cycles. The next FETCH begins the cycle after EXECUTE.
- Outputs are decoded from the state register and IR only, with no combinational path from `instr_in`. `alu_zero` and `alu_neg` affect only the flag registers.
- Reset: at a rising edge with `rst_n`=0, state becomes FETCH and IR and flags clear to 0.
  - While `rst_n`=0, every output is forced to 0.
  - The first `ir_wr`=1 appears in the first cycle after reset with `rst_n`=1.
- Reset in any state, including mid-EXECUTE or HALT, aborts with no strobe in that cycle.
- A flag update and a branch never coincide: a branch reads flags written by an earlier instruction.

## Structure
- Package `control_pkg` holds:
  - opcode enum;
  - `alu_op` enum;
  - `sel_A` encodings (`SEL_A_IMM`=00, `SEL_A_MEM`=01, `SEL_A_ALU`=10);
  - state enum (FETCH, DECODE, EXECUTE, HALT).
- Sub-module `instr_decoder` is combinational. It maps opcode to {`sel_A`, `sel_B`, `alu_op`, writes_acc, writes_mem, is_alu, branch_cond}.
- The top level holds the FSM, IR, flags and strobe gating.

## Test plan
- Reset held 2 cycles, then released -> all outputs 0 during reset; `ir_wr`=1 in the first cycle after release; `operand`=0.
- LDI 5 (16'h1805) -> EXECUTE: `sel_A`=00, `acc_wr`=1, `pc_wr`=1, `pc_sel`=0. LD 3 -> `sel_A`=01. ADDI 2 -> `sel_A`=10, `sel_B`=1, `alu_op`=000.
- SUBI with `alu_zero`=1, then BEQ 40 -> BEQ EXECUTE: `pc_wr`=1, `pc_sel`=1, `operand`=40. Same with `alu_zero`=0 -> `pc_sel`=0.
- SUB with `alu_neg`=1, then BGE 7 -> `pc_sel`=0; BLT 7 -> `pc_sel`=1. A JMP between them leaves the flags unchanged.
- STO 9 -> `mem_wr`=1 only in EXECUTE, `acc_wr`=0. HLT -> `pc_wr`=0, then `halted`=1 indefinitely with all strobes 0.
- Reset asserted during an EXECUTE of ADD -> no `acc_wr` that cycle and flags cleared; after release, FETCH restarts.
